// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: memsize encodings, FSM state type and access-size helper for the load/store unit
package riscv_lsu_pkg;
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_D  = 3'b011;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;
    localparam logic [2:0] MEM_WU = 3'b110;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} lsu_state_t;

    // Byte count of an access; the undefined 111 encoding has no size
    function automatic logic [3:0] size_bytes(input logic [2:0] memsize);
        return (memsize == 3'b111) ? 4'd0 : 4'd1 << memsize[1:0];
    endfunction
endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: store byte-enable/lane steering and load lane extraction with sign/zero extension (second-beat ports only with RISCV_LSU_MISALIGNED_EN)
module riscv_lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  logic [2:0]                memsize,
    input  logic [XLEN-1:0]           wdata,
    input  logic [XLEN-1:0]           rdLo,
`ifdef RISCV_LSU_MISALIGNED_EN
    input  logic [XLEN-1:0]           rdHi,
    output logic [XLEN/8-1:0]         be1,
    output logic [XLEN-1:0]           wd1,
`endif
    output logic [XLEN/8-1:0]         be0,
    output logic [XLEN-1:0]           wd0,
    output logic [XLEN-1:0]           loadData
);
    localparam int NB   = XLEN / 8;
    localparam int NB2  = 2 * NB;
    localparam int OFFW = $clog2(NB);

    logic [3:0]      bytes;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] topBit;
`ifdef RISCV_LSU_MISALIGNED_EN
    logic [OFFW:0]   rem;
`endif

    // Steer store lanes to the offset and pull load lanes back to bit 0 before extending
    always_comb begin
        bytes    = size_bytes(memsize);
        be0      = NB'(((NB2'(1) << bytes) - NB2'(1)) << offset);
        wd0      = wdata << {offset, 3'b000};
`ifdef RISCV_LSU_MISALIGNED_EN
        rem      = (OFFW+1)'(NB) - (OFFW+1)'(offset);
        be1      = NB'((((NB2'(1) << bytes) - NB2'(1)) << offset) >> NB);
        wd1      = wdata >> {rem, 3'b000};
        shifted  = XLEN'({rdHi, rdLo} >> {offset, 3'b000});
`else
        shifted  = rdLo >> {offset, 3'b000};
`endif
        mask     = (bytes >= 4'(NB)) ? '1 : (XLEN'(1) << {bytes, 3'b000}) - XLEN'(1);
        topBit   = mask & ~(mask >> 1);
        loadData = (shifted & mask) | ((!memsize[2] && |(shifted & topBit)) ? ~mask : '0);
    end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: handshaked load/store unit with lane steering and load extension; define RISCV_LSU_MISALIGNED_EN to split line-crossing accesses into two beats
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    input  logic              memwrite_i,
    input  logic [2:0]        memsize_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [XLEN/8-1:0] bus_be_o,
    output logic [XLEN-1:0]   bus_wdata_o,
    input  logic              bus_ready_i,
    input  logic [XLEN-1:0]   bus_rdata_i
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_t      state;
    logic            opWe;
    logic [2:0]      opSize;
    logic [OFFW-1:0] opOffset;
    logic [OFFW-1:0] offSel;
    logic [2:0]      sizeSel;
    logic [XLEN-1:0] wdataSel;
    logic [XLEN-1:0] rdLo;
    logic [NB-1:0]   be0;
    logic [XLEN-1:0] wd0;
    logic [XLEN-1:0] loadData;
    logic [3:0]      reqBytes;
    logic            illegal;
    logic            reject;
`ifdef RISCV_LSU_MISALIGNED_EN
    logic            opSplit;
    logic            crossing;
    logic [XLEN-1:0] opWdata;
    logic [XLEN-1:0] rdBeat0;
    logic [NB-1:0]   be1;
    logic [XLEN-1:0] wd1;
`endif

    // Classify the live request; feed the aligner from it in IDLE and from the captured op afterwards
    always_comb begin
        reqBytes = size_bytes(memsize_i);
        illegal  = (memsize_i == 3'b111) || (XLEN == 32 && (memsize_i == MEM_D || memsize_i == MEM_WU));
        offSel   = (state == IDLE) ? addr_i[OFFW-1:0] : opOffset;
        sizeSel  = (state == IDLE) ? memsize_i : opSize;
`ifdef RISCV_LSU_MISALIGNED_EN
        crossing = (5'(addr_i[OFFW-1:0]) + 5'(reqBytes)) > 5'(NB);
        reject   = illegal;
        wdataSel = (state == IDLE) ? wdata_i : opWdata;
        rdLo     = (state == BEAT1) ? rdBeat0 : bus_rdata_i;
`else
        reject   = illegal || |(addr_i[OFFW-1:0] & OFFW'(reqBytes - 4'd1));
        wdataSel = wdata_i;
        rdLo     = bus_rdata_i;
`endif
        stall_o  = req_valid_i && state != DONE && !reset;
    end

    riscv_lsu_align #(.XLEN(XLEN)) uAlign (
        .offset   (offSel),
        .memsize  (sizeSel),
        .wdata    (wdataSel),
        .rdLo     (rdLo),
`ifdef RISCV_LSU_MISALIGNED_EN
        .rdHi     (bus_rdata_i),
        .be1      (be1),
        .wd1      (wd1),
`endif
        .be0      (be0),
        .wd0      (wd0),
        .loadData (loadData)
    );

    // Sequence IDLE -> beat(s) -> DONE and register every bus and result output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            opWe        <= 1'b0;
            opSize      <= '0;
            opOffset    <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
`ifdef RISCV_LSU_MISALIGNED_EN
            opSplit     <= 1'b0;
            opWdata     <= '0;
            rdBeat0     <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: if (req_valid_i) begin
                    opWe        <= memwrite_i;
                    opSize      <= memsize_i;
                    opOffset    <= addr_i[OFFW-1:0];
`ifdef RISCV_LSU_MISALIGNED_EN
                    opSplit     <= crossing;
                    opWdata     <= wdata_i;
`endif
                    state       <= reject ? DONE : BEAT0;
                    done_o      <= reject;
                    err_o       <= reject;
                    rdata_o     <= '0;
                    bus_req_o   <= !reject;
                    bus_we_o    <= !reject && memwrite_i;
                    bus_addr_o  <= reject ? '0 : {addr_i[ADDR_W-1:OFFW], OFFW'(0)};
                    bus_be_o    <= reject ? '0 : be0;
                    bus_wdata_o <= reject ? '0 : wd0;
                end
                BEAT0, BEAT1: if (bus_ready_i) begin
`ifdef RISCV_LSU_MISALIGNED_EN
                    if (state == BEAT0 && opSplit) begin
                        state       <= BEAT1;
                        rdBeat0     <= bus_rdata_i;
                        bus_addr_o  <= bus_addr_o + ADDR_W'(NB);
                        bus_be_o    <= be1;
                        bus_wdata_o <= wd1;
                    end else begin
`else
                    begin
`endif
                        state       <= DONE;
                        done_o      <= 1'b1;
                        rdata_o     <= opWe ? '0 : loadData;
                        bus_req_o   <= 1'b0;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= '0;
                        bus_be_o    <= '0;
                        bus_wdata_o <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Parametrised load/store unit between the memory stage of the pipelined RISC-V core and a ready/valid data bus. It replaces the zero-wait-state combinational data port with a handshaked, multi-cycle access that stalls the pipeline. It performs byte-lane steering, byte-enable generation and load sign/zero extension. Misaligned accesses are optionally split into two bus beats.

## Interface
- XLEN, 32: data width; legal values are 32 and 64.
- ADDR_W, 32: byte-address width.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  memory stage holds a load or store.
- memwrite_i  in  1  1 = store, 0 = load.
- memsize_i  in  3  funct3 encoding:
  - 000 B, 001 H, 010 W, 011 D (XLEN=64 only).
  - 100 BU, 101 HU, 110 WU (XLEN=64 only).
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  XLEN  store data, right-aligned.
- stall_o  out  1  freeze the pipeline.
- done_o  out  1  one-cycle pulse when the access completes.
- rdata_o  out  XLEN  extended load result; valid while done_o is high.
- err_o  out  1  one-cycle pulse with done_o for an illegal or unsupported access.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write.
- bus_addr_o  out  ADDR_W  bus address, XLEN/8-aligned.
- bus_be_o  out  XLEN/8  byte enables.
- bus_wdata_o  out  XLEN  lane-steered write data.
- bus_ready_i  in  1  beat accepted; bus_rdata_i is valid in the same cycle.
- bus_rdata_i  in  XLEN  read data.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- IDLE:
  - On req_valid_i, capture the operation, size, address, offset = addr_i mod XLEN/8, and wdata.
  - Classify the access:
    - Illegal size: 011 or 110 when XLEN=32, or 111. Go to DONE with err_o.
    - Crossing: offset + bytes > XLEN/8.
    - Otherwise go to BEAT0.
- BEAT0:
  - Drive bus_req_o=1.
  - bus_addr_o = addr with the low bits cleared.
  - bus_be_o = ((1<<bytes)-1) << offset, truncated to XLEN/8 bits.
  - bus_wdata_o = wdata << 8·offset.
  - On bus_ready_i: latch read lanes. If crossing, go to BEAT1; otherwise go to DONE.
- BEAT1:
  - bus_addr_o = BEAT0 address + XLEN/8, with wrap-around at 2^ADDR_W.
  - bus_be_o = the remaining low lanes.
  - bus_wdata_o = wdata >> 8·(XLEN/8 − offset).
  - On bus_ready_i, latch read lanes and go to DONE.
- DONE:
  - Assert done_o for one cycle.
  - rdata_o = assembled bytes shifted to bit 0, then sign-extended (B/H/W) or zero-extended (BU/HU/WU/D).
  - Return to IDLE.
- Stores drive rdata_o = 0.
- stall_o = req_valid_i && state≠DONE, combinational. The pipeline advances on the DONE cycle.
- While bus_req_o=1, all bus outputs hold stable until bus_ready_i.
- bus_ready_i outside BEAT0/BEAT1 is ignored.
- req_valid_i is sampled only in IDLE. Dropping it mid-access does not abort the access; the unit still completes and pulses done_o.

## Timing
- Reset (asynchronous, any state):
  - State → IDLE.
  - bus_req_o, bus_we_o, done_o, err_o, stall_o driven 0; bus_be_o, bus_addr_o, bus_wdata_o, rdata_o driven 0.
  - An in-flight beat is abandoned.
- All bus outputs, done_o, err_o and rdata_o are registered.
- Aligned access with ready on first cycle:
  - Request at edge 0 → BEAT0 in cycle 1 → DONE in cycle 2.
  - Stall is 2 cycles.
- Each wait cycle (bus_ready_i=0) adds one cycle.
- Split access adds one beat, minimum 3 stall cycles.
- Error path: IDLE → DONE, 1 stall cycle, no bus activity.
- Back-to-back: a new req_valid_i in the cycle after DONE is accepted immediately.

## Configuration
- RISCV_LSU_MISALIGNED_EN:
  - Defined: crossing accesses are split into BEAT0+BEAT1 as above.
  - Undefined: any access whose address is not naturally aligned for its size goes IDLE → DONE with err_o=1 and no bus request. BEAT1 logic and the split-data register are not synthesised.

## Structure
- Package riscv_lsu_pkg:
  - memsize encoding constants (MEM_B … MEM_WU).
  - lsu_state_t enum.
  - function size_bytes(memsize).
- Sub-module riscv_lsu_align (combinational):
  - Store side: byte-enable and write-lane steering.
  - Load side: lane extraction and sign/zero extension.
  - Instantiated once; takes XLEN as a parameter.

## Test plan
- XLEN=32, LW addr 0x100, ready on first cycle, bus_rdata 0xDEADBEEF:
  - stall 2 cycles, rdata_o=0xDEADBEEF, bus_be_o=4'b1111.
- LB addr 0x103, bus_rdata 0x80xxxxxx → rdata_o=0xFFFFFF80.
- LBU, same stimulus → rdata_o=0x00000080.
- SH addr 0x102, wdata 0x1234:
  - bus_be_o=4'b1100, bus_wdata_o=0x12340000, bus_we_o=1.
- bus_ready_i held low 3 cycles:
  - bus outputs stable, stall_o high 5 cycles, single done_o.
- LW addr 0x0FE:
  - With macro: beats at 0x0FC (be 1100) and 0x100 (be 0011); rdata_o assembled from both beats.
  - Without macro: err_o=1, no bus_req_o.
- Reset asserted mid-BEAT0:
  - bus_req_o drops immediately; state IDLE.
  - The next request completes normally.
